// File: rtl/fta_split256to32.sv
// fta_split256to32: sequential 256-to-32 bit FTA width splitter.
// One 32-bit beat per active lane, gathered into one 256-bit response.
package fta_pkg;

    localparam logic [2:0] SZ_BYTE  = 3'd0;
    localparam logic [2:0] SZ_WYDE  = 3'd1;
    localparam logic [2:0] SZ_TETRA = 3'd2;
    localparam logic [2:0] SZ_OCTA  = 3'd3;
    localparam logic [2:0] SZ_HEXI  = 3'd4;

    localparam logic [2:0] CTI_CLASSIC = 3'd0;

    typedef struct packed {
        logic         cyc;
        logic         we;
        logic [7:0]   tid;
        logic [1:0]   om;
        logic [4:0]   cmd;
        logic [3:0]   seg;
        logic         pv;
        logic [7:0]   pl;
        logic [3:0]   pri;
        logic [3:0]   cache;
        logic         csr;
        logic [2:0]   cti;
        logic [5:0]   blen;
        logic [2:0]   sz;
        logic [31:0]  adr;
        logic [31:0]  sel;
        logic [255:0] data1;
    } fta_cmd_request256_t;

    typedef struct packed {
        logic         cyc;
        logic         we;
        logic [7:0]   tid;
        logic [1:0]   om;
        logic [4:0]   cmd;
        logic [3:0]   seg;
        logic         pv;
        logic [7:0]   pl;
        logic [3:0]   pri;
        logic [3:0]   cache;
        logic         csr;
        logic [2:0]   cti;
        logic [5:0]   blen;
        logic [2:0]   sz;
        logic [31:0]  adr;
        logic [3:0]   sel;
        logic [31:0]  dat;
    } fta_cmd_request32_t;

    typedef struct packed {
        logic         ack;
        logic         err;
        logic         rty;
        logic         stall;
        logic         next;
        logic [7:0]   tid;
        logic [3:0]   pri;
        logic [31:0]  adr;
        logic [255:0] dat;
    } fta_cmd_response256_t;

    typedef struct packed {
        logic         ack;
        logic         err;
        logic         rty;
        logic         stall;
        logic         next;
        logic [7:0]   tid;
        logic [3:0]   pri;
        logic [31:0]  adr;
        logic [31:0]  dat;
    } fta_cmd_response32_t;

endpackage

module fta_split256to32
    import fta_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 1023,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                 rst_ni,
    input  logic                 clk_i,
    input  fta_cmd_request256_t  req256_i,
    output fta_cmd_response256_t resp256_o,
    output fta_cmd_request32_t   req32_o,
    input  fta_cmd_response32_t  resp32_i
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    fta_cmd_request256_t req_q;
    logic [7:0]          pend_q;
    logic [2:0]          cur_q;
    logic [255:0]        buf_q;
    logic                err_q;
    logic [RW-1:0]       rty_q;
    logic [9:0]          tmo_q;

    logic [7:0] lane_mask;
    logic [7:0] pend_rest;
    logic       tid_ok;
    logic       ev_ack;
    logic       ev_err;
    logic       ev_rty;
    logic       retry_left;
    logic       tmo_hit;
    logic       beat_bad;
    logic       beat_done;
    logic       beat_retry;
    logic       unused_ok;

    function automatic logic [7:0] lanes(input logic [31:0] s);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++)
            m[i] = |s[4*i +: 4];
        return m;
    endfunction

    function automatic logic [2:0] lowest(input logic [7:0] m);
        logic [2:0] l;
        l = '0;
        for (int i = 7; i >= 0; i--)
            if (m[i])
                l = 3'(i);
        return l;
    endfunction

    assign lane_mask  = lanes(req256_i.sel);
    assign pend_rest  = pend_q & ~(8'b1 << cur_q);
    assign tid_ok     = resp32_i.tid == req_q.tid;
    assign ev_ack     = tid_ok & resp32_i.ack;
    assign ev_err     = tid_ok & resp32_i.err;
    assign ev_rty     = tid_ok & resp32_i.rty;
    assign retry_left = rty_q < RW'(MAX_RETRY);
    assign tmo_hit    = tmo_q == 10'(TIMEOUT - 1);

    // err beats ack beats rty; exhausted retries and timeouts degrade to err
    assign beat_bad   = ev_err
                      | (!ev_ack & ev_rty & !retry_left)
                      | (!ev_ack & !ev_rty & tmo_hit);
    assign beat_done  = ev_ack | beat_bad;
    assign beat_retry = !beat_done & ev_rty;

    assign unused_ok  = ^{req_q.cyc, req_q.cti, req_q.blen,
                          resp32_i.pri, resp32_i.adr,
                          resp32_i.next};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        req32_o         = '0;
        resp256_o       = '0;
        resp256_o.stall = 1'b1;
        unique case (state_q)
            IDLE: begin
                resp256_o.stall = 1'b0;
                if (req256_i.cyc)
                    state_d = (lane_mask == 8'h00) ? DONE : ISSUE;
            end
            ISSUE: begin
                req32_o.cyc   = 1'b1;
                req32_o.we    = req_q.we;
                req32_o.tid   = req_q.tid;
                req32_o.om    = req_q.om;
                req32_o.cmd   = req_q.cmd;
                req32_o.seg   = req_q.seg;
                req32_o.pv    = req_q.pv;
                req32_o.pl    = req_q.pl;
                req32_o.pri   = req_q.pri;
                req32_o.cache = req_q.cache;
                req32_o.csr   = req_q.csr;
                req32_o.cti   = CTI_CLASSIC;
                req32_o.blen  = '0;
                req32_o.adr   = {req_q.adr[31:5], cur_q, 2'b00};
                req32_o.sel   = req_q.sel[4*cur_q +: 4];
                req32_o.dat   = req_q.data1[32*cur_q +: 32];
                req32_o.sz    = (req_q.sz == SZ_BYTE ||
                                 req_q.sz == SZ_WYDE ||
                                 req_q.sz == SZ_TETRA)
                              ? req_q.sz : SZ_TETRA;
                if (!resp32_i.stall)
                    state_d = WAIT;
            end
            WAIT: begin
                if (beat_done)
                    state_d = (pend_rest == 8'h00) ? DONE : ISSUE;
                else if (beat_retry)
                    state_d = ISSUE;
            end
            DONE: begin
                resp256_o.ack = !err_q;
                resp256_o.err = err_q;
                resp256_o.dat = req_q.we ? '0 : buf_q;
                resp256_o.tid = req_q.tid;
                resp256_o.adr = req_q.adr;
                resp256_o.pri = req_q.pri;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q  <= '0;
            pend_q <= '0;
            cur_q  <= '0;
            buf_q  <= '0;
            err_q  <= 1'b0;
            rty_q  <= '0;
            tmo_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req256_i.cyc) begin
                        req_q  <= req256_i;
                        pend_q <= lane_mask;
                        cur_q  <= lowest(lane_mask);
                        buf_q  <= '0;
                        err_q  <= 1'b0;
                        rty_q  <= '0;
                        tmo_q  <= '0;
                    end
                end
                ISSUE: tmo_q <= '0;
                WAIT: begin
                    tmo_q <= tmo_q + 10'd1;
                    if (beat_done) begin
                        buf_q[32*cur_q +: 32] <= beat_bad ? 32'h0
                                                          : resp32_i.dat;
                        err_q  <= err_q | beat_bad;
                        rty_q  <= '0;
                        pend_q <= pend_rest;
                        cur_q  <= lowest(pend_rest);
                    end else if (beat_retry) begin
                        rty_q <= rty_q + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fta_split256to32.sv
// tb_fta_split256to32: scoreboard bench with a behavioural slave,
// a lane-level reference model and a decoupled response monitor.
module tb_fta_split256to32;
    import fta_pkg::*;

    localparam int TMO = 1023;
    localparam int MR  = 3;

    typedef struct {
        logic [319:0] resp;
        int           acc;
        int           lat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_ni;
    fta_cmd_request256_t  req256;
    fta_cmd_response256_t resp256;
    fta_cmd_request32_t   req32;
    fta_cmd_response32_t  resp32;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    exp_t         exp_q[$];
    logic [95:0]  beat_q[$];

    int           stall_left = 0;
    int           rty_left   = 0;
    bit           silent     = 1'b0;
    bit           junk_once  = 1'b0;
    logic [31:0]  data_key   = 32'h0;

    fta_cmd_response32_t pend_r;
    bit                  have_pend = 1'b0;
    bit                  junk_pend = 1'b0;
    bit                  snap_v    = 1'b0;
    logic [95:0]         snap;

    fta_split256to32 #(.TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
        .rst_ni    (rst_ni),
        .clk_i     (clk),
        .req256_i  (req256),
        .resp256_o (resp256),
        .req32_o   (req32),
        .resp32_i  (resp32)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [319:0] act,
                       input logic [319:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    function automatic logic [95:0] beat_vec(
        input logic [31:0] adr, input logic [3:0] sel,
        input logic [31:0] dat, input logic [2:0] sz, input logic we,
        input logic [7:0] tid, input logic [3:0] pri,
        input logic [2:0] cti, input logic [5:0] blen);
        return {3'b0, adr, sel, dat, sz, we, tid, pri, cti, blen};
    endfunction

    function automatic logic [95:0] dut_beat();
        return beat_vec(req32.adr, req32.sel, req32.dat, req32.sz,
                        req32.we, req32.tid, req32.pri, req32.cti,
                        req32.blen);
    endfunction

    // behavioural 32-bit slave; also checks every accepted beat
    initial begin
        fta_cmd_response32_t r;
        resp32 = '0;
        forever begin
            @(negedge clk);
            r = '0;
            if (!rst_ni) begin
                have_pend = 1'b0;
                junk_pend = 1'b0;
                snap_v    = 1'b0;
            end else if (have_pend) begin
                r = pend_r;
                if (junk_pend) begin
                    r.tid     = pend_r.tid ^ 8'h01;
                    junk_pend = 1'b0;
                end else begin
                    have_pend = 1'b0;
                end
            end else if (req32.cyc) begin
                if (stall_left > 0) begin
                    if (snap_v) chk("stall_hold", dut_beat(), snap);
                    else snap = dut_beat();
                    snap_v  = 1'b1;
                    r.stall = 1'b1;
                    stall_left--;
                end else begin
                    if (snap_v) chk("stall_hold", dut_beat(), snap);
                    snap_v = 1'b0;
                    if (beat_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got adr %h, required none",
                                 req32.adr);
                    end else begin
                        chk("beat", dut_beat(), beat_q.pop_front());
                    end
                    if (!silent) begin
                        pend_r     = '0;
                        pend_r.tid = req32.tid;
                        pend_r.dat = data_key + 32'(req32.adr[4:2]);
                        if (rty_left > 0) begin
                            pend_r.rty = 1'b1;
                            rty_left--;
                        end else begin
                            pend_r.ack = 1'b1;
                        end
                        have_pend = 1'b1;
                        junk_pend = junk_once;
                        junk_once = 1'b0;
                    end
                end
            end
            resp32 = r;
        end
    end

    // response monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_ni && (resp256.ack || resp256.err)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got ack=%0b err=%0b, required none",
                             resp256.ack, resp256.err);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp", {18'b0, resp256.ack, resp256.err,
                                 resp256.tid, resp256.pri,
                                 resp256.adr, resp256.dat}, e.resp);
                    chk("latency", 320'(cyc_cnt - e.acc), 320'(e.lat));
                end
            end
        end
    end

    // reference: lanes in ascending order, one issue per lane plus retries
    task automatic model(input fta_cmd_request256_t r, input int rty,
                         input bit sil, input bit junk, input int stall,
                         input logic [31:0] key, output exp_t e);
        logic [255:0] d;
        logic [3:0]   nib;
        logic [2:0]   sz;
        bit           err;
        bit           first;
        int           total;
        int           nl;
        int           rr;
        int           iss;
        d     = '0;
        err   = 1'b0;
        first = 1'b1;
        total = 0;
        nl    = 0;
        sz    = (r.sz <= SZ_TETRA) ? r.sz : SZ_TETRA;
        for (int l = 0; l < 8; l++) begin
            nib = r.sel[4*l +: 4];
            if (nib != 4'h0) begin
                rr    = first ? rty : 0;
                first = 1'b0;
                iss   = (rr > MR) ? MR + 1 : rr + 1;
                for (int k = 0; k < iss; k++)
                    beat_q.push_back(beat_vec(
                        {r.adr[31:5], 5'(l * 4)}, nib,
                        r.data1[32*l +: 32], sz, r.we, r.tid, r.pri,
                        CTI_CLASSIC, 6'd0));
                total += iss;
                nl++;
                if (sil || rr > MR) err = 1'b1;
                else d[32*l +: 32] = key + 32'(l);
            end
        end
        e.resp = {18'b0, !err, err, r.tid, r.pri, r.adr,
                  r.we ? 256'b0 : d};
        e.lat  = 1 + 2 * total + stall
               + (sil ? nl * (TMO - 1) : 0)
               + ((junk && total > 0) ? 1 : 0);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!resp256.stall) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL idle_wait: got stall=1 for 3000 cycles, required 0");
        end
    endtask

    task automatic drive(input fta_cmd_request256_t r);
        req256     = r;
        req256.cyc = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req256.cyc = 1'b0;
        chk("busy_stall", 320'(resp256.stall), 320'(1));
    endtask

    task automatic issue(input fta_cmd_request256_t r, input int stall,
                         input int rty, input bit sil, input bit junk,
                         input logic [31:0] key);
        exp_t e;
        wait_idle();
        model(r, rty, sil, junk, stall, key, e);
        stall_left = stall;
        rty_left   = rty;
        silent     = sil;
        junk_once  = junk;
        data_key   = key;
        e.acc      = cyc_cnt;
        exp_q.push_back(e);
        drive(r);
    endtask

    function automatic fta_cmd_request256_t rand_req();
        fta_cmd_request256_t r;
        r       = '0;
        r.we    = 1'($urandom);
        r.tid   = 8'($urandom);
        r.om    = 2'($urandom);
        r.cmd   = 5'($urandom);
        r.seg   = 4'($urandom);
        r.pv    = 1'($urandom);
        r.pl    = 8'($urandom);
        r.pri   = 4'($urandom);
        r.cache = 4'($urandom);
        r.csr   = 1'($urandom);
        r.sz    = 3'($urandom_range(0, 4));
        r.adr   = $urandom;
        for (int l = 0; l < 8; l++) begin
            r.data1[32*l +: 32] = $urandom;
            case ($urandom_range(0, 3))
                0: r.sel[4*l +: 4] = 4'h0;
                1: r.sel[4*l +: 4] = 4'hF;
                default: r.sel[4*l +: 4] = 4'($urandom);
            endcase
        end
        return r;
    endfunction

    initial begin
        fta_cmd_request256_t r;
        bit drained;
        rst_ni = 1'b0;
        req256 = '0;
        repeat (3) @(negedge clk);
        chk("reset_req32", 320'(req32), 320'(0));
        chk("reset_resp256", 320'(resp256), 320'(0));
        rst_ni = 1'b1;

        r       = rand_req();
        r.we    = 1'b0;
        r.sz    = SZ_HEXI;
        r.adr   = 32'h1000;
        r.sel   = 32'hFFFF_FFFF;
        issue(r, 0, 0, 1'b0, 1'b0, 32'h1111_0000);

        r       = rand_req();
        r.we    = 1'b1;
        r.sz    = SZ_TETRA;
        r.adr   = 32'h2000;
        r.sel   = 32'h0F00_00F0;
        r.data1[63:32]   = 32'hA5A5_A5A5;
        r.data1[223:192] = 32'h5A5A_5A5A;
        issue(r, 0, 0, 1'b0, 1'b0, $urandom);

        r       = rand_req();
        r.we    = 1'b0;
        r.sz    = SZ_BYTE;
        r.sel   = 32'h0000_0100;
        issue(r, 0, 0, 1'b0, 1'b0, $urandom);

        r       = rand_req();
        r.we    = 1'b0;
        r.sel   = 32'h0000_00FF;
        issue(r, 0, 3, 1'b0, 1'b0, $urandom);
        r.tid   = r.tid + 8'd1;
        issue(r, 0, 4, 1'b0, 1'b0, $urandom);

        r       = rand_req();
        r.sel   = 32'h0000_F000;
        issue(r, 5, 0, 1'b1, 1'b0, $urandom);
        wait_idle();
        silent = 1'b0;

        r       = rand_req();
        r.sel   = 32'h00FF_0000;
        issue(r, 0, 0, 1'b0, 1'b1, $urandom);

        r       = rand_req();
        r.sel   = 32'h0;
        issue(r, 0, 0, 1'b0, 1'b0, $urandom);

        // reset while lane 0 of a 4-lane read waits on a silent slave
        r       = rand_req();
        r.we    = 1'b0;
        r.sz    = SZ_TETRA;
        r.sel   = 32'h0000_FFFF;
        wait_idle();
        beat_q.push_back(beat_vec({r.adr[31:5], 5'd0}, 4'hF,
                                  r.data1[31:0], SZ_TETRA, 1'b0, r.tid,
                                  r.pri, CTI_CLASSIC, 6'd0));
        silent     = 1'b1;
        stall_left = 0;
        rty_left   = 0;
        drive(r);
        repeat (10) @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("midwait_req32", 320'(req32), 320'(0));
        chk("midwait_resp256", 320'(resp256), 320'(0));
        repeat (2) @(negedge clk);
        silent = 1'b0;
        rst_ni = 1'b1;
        repeat (20) @(negedge clk);
        chk("midwait_beatq", 320'(beat_q.size()), 320'(0));
        issue(r, 0, 0, 1'b0, 1'b0, $urandom);

        for (int n = 0; n < 25; n++)
            issue(rand_req(), $urandom_range(0, 3), $urandom_range(0, 4),
                  1'b0, 1'($urandom), $urandom);

        drained = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        chk("drain_resp", 320'(drained), 320'(1));
        chk("drain_beats", 320'(beat_q.size()), 320'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
